// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - register offsets and byte-lane helper for the Wishbone GPIO
package gpio_pkg;

  localparam logic [2:0] GPIO_IN      = 3'd0;
  localparam logic [2:0] GPIO_OUT     = 3'd1;
  localparam logic [2:0] GPIO_OE      = 3'd2;
  localparam logic [2:0] GPIO_INTE    = 3'd3;
  localparam logic [2:0] GPIO_PTRIG   = 3'd4;
  localparam logic [2:0] GPIO_INTS    = 3'd5;
  localparam logic [2:0] GPIO_OUT_SET = 3'd6;
  localparam logic [2:0] GPIO_OUT_CLR = 3'd7;

  typedef enum logic [2:0] {
    REG_IN      = GPIO_IN,
    REG_OUT     = GPIO_OUT,
    REG_OE      = GPIO_OE,
    REG_INTE    = GPIO_INTE,
    REG_PTRIG   = GPIO_PTRIG,
    REG_INTS    = GPIO_INTS,
    REG_OUT_SET = GPIO_OUT_SET,
    REG_OUT_CLR = GPIO_OUT_CLR
  } gpio_reg_e;

  // Zeroes every byte of value whose lane select is low.
  function automatic logic [31:0] apply_sel(input logic [31:0] value, input logic [3:0] sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = sel[b] ? value[b*8 +: 8] : 8'h00;
    end
    return res;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// rtl/gpio_sync_edge.sv - pad input synchroniser with per-pin edge detection
module gpio_sync_edge #(
  parameter int GW          = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [GW-1:0] async_in,
  input  logic [GW-1:0] ptrig,
  output logic [GW-1:0] sync_out,
  output logic [GW-1:0] edge_out
);

  logic [SYNC_STAGES-1:0][GW-1:0] sync_q;
  logic [GW-1:0]                  prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  // Polarity only selects which transition counts; flipping it cannot fake an edge.
  assign edge_out = (ptrig & sync_out & ~prev_q) | (~ptrig & ~sync_out & prev_q);

endmodule

// File: rtl/gpio_wb_irq.sv
// rtl/gpio_wb_irq.sv - Wishbone GPIO slave with edge interrupts and atomic set/clear
module gpio_wb_irq
  import gpio_pkg::*;
#(
  parameter int GW          = 24,
  parameter int AW          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [31:0]   wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  output logic [31:0]   wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_inta_o,
  input  logic [GW-1:0] i_gpio,
  output logic [GW-1:0] o_gpio,
  output logic [GW-1:0] en_gpio
);

  logic [GW-1:0] out_r, oe_r, inte_r, ptrig_r, ints_r;
  logic [GW-1:0] sync_v, edge_v;
  logic [GW-1:0] out_next, ints_next, w1c_mask;
  logic [31:0]   lane_mask, wdata, rdata, merged;
  logic          acc, adr_ok, wr;
  gpio_reg_e     reg_sel;
  logic          unused_bits;

  gpio_sync_edge #(
    .GW          (GW),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .async_in (i_gpio),
    .ptrig    (ptrig_r),
    .sync_out (sync_v),
    .edge_out (edge_v)
  );

  // The pending ack/err blocks re-acceptance, giving the one idle cycle between accesses.
  assign acc       = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign adr_ok    = (wb_adr_i >> 5) == '0;
  assign wr        = acc & adr_ok & wb_we_i;
  assign reg_sel   = gpio_reg_e'(wb_adr_i[4:2]);
  assign lane_mask = apply_sel(32'hFFFF_FFFF, wb_sel_i);
  assign wdata     = apply_sel(wb_dat_i, wb_sel_i);

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_IN:    rdata[GW-1:0] = sync_v;
      REG_OUT:   rdata[GW-1:0] = out_r;
      REG_OE:    rdata[GW-1:0] = oe_r;
      REG_INTE:  rdata[GW-1:0] = inte_r;
      REG_PTRIG: rdata[GW-1:0] = ptrig_r;
      REG_INTS:  rdata[GW-1:0] = ints_r;
      default:   rdata = '0;
    endcase
  end

  assign merged = (rdata & ~lane_mask) | wdata;

  always_comb begin
    out_next = out_r;
    w1c_mask = '0;
    if (wr) begin
      case (reg_sel)
        REG_OUT:     out_next = merged[GW-1:0];
        REG_OUT_SET: out_next = out_r | wdata[GW-1:0];
        REG_OUT_CLR: out_next = out_r & ~wdata[GW-1:0];
        REG_INTS:    w1c_mask = wdata[GW-1:0];
        default:     out_next = out_r;
      endcase
    end
  end

  // A fresh edge outranks a simultaneous clear of the same bit.
  assign ints_next = (ints_r & ~w1c_mask) | edge_v;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      out_r     <= '0;
      oe_r      <= '0;
      inte_r    <= '0;
      ptrig_r   <= '0;
      ints_r    <= '0;
      wb_ack_o  <= 1'b0;
      wb_err_o  <= 1'b0;
      wb_dat_o  <= '0;
      wb_inta_o <= 1'b0;
    end else begin
      wb_ack_o  <= acc & adr_ok;
      wb_err_o  <= acc & ~adr_ok;
      out_r     <= out_next;
      ints_r    <= ints_next;
      wb_inta_o <= |(ints_next & inte_r);
      if (acc && !adr_ok) begin
        wb_dat_o <= '0;
      end else if (acc && !wb_we_i) begin
        wb_dat_o <= rdata;
      end
      if (wr) begin
        case (reg_sel)
          REG_OE:    oe_r    <= merged[GW-1:0];
          REG_INTE:  inte_r  <= merged[GW-1:0];
          REG_PTRIG: ptrig_r <= merged[GW-1:0];
          default:   ;
        endcase
      end
    end
  end

  assign o_gpio      = out_r;
  assign en_gpio     = oe_r;
  assign unused_bits = ^{merged, wdata, wb_adr_i[1:0]};

endmodule

// File: tb/tb_gpio_wb_irq.sv
// tb/tb_gpio_wb_irq.sv - scoreboard bench for the Wishbone GPIO slave
module tb_gpio_wb_irq;

  localparam int GW = 24;
  localparam int AW = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cyc, stb, we;
  logic [AW-1:0] adr;
  logic [31:0]   dat_i;
  logic [3:0]    sel;
  logic [31:0]   dat_o;
  logic          ack, err, inta;
  logic [GW-1:0] gpio_in, gpio_out, gpio_en;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        err;
    logic [31:0] dat;
    logic        chk;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  gpio_wb_irq #(.GW(GW), .AW(AW), .SYNC_STAGES(SS)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wb_cyc_i  (cyc),
    .wb_stb_i  (stb),
    .wb_we_i   (we),
    .wb_adr_i  (adr),
    .wb_dat_i  (dat_i),
    .wb_sel_i  (sel),
    .wb_dat_o  (dat_o),
    .wb_ack_o  (ack),
    .wb_err_o  (err),
    .wb_inta_o (inta),
    .i_gpio    (gpio_in),
    .o_gpio    (gpio_out),
    .en_gpio   (gpio_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Response monitor: pops one expectation per ack/err pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ack || err) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_response: got ack=%0b err=%0b dat=%h with nothing expected", ack, err, dat_o);
        end else begin
          e = exp_q.pop_front();
          if (err !== e.err || ack !== !e.err || (e.chk && dat_o !== e.dat)) begin
            n_bad++;
            $display("FAIL %s: got ack=%0b err=%0b dat=%h want err=%0b dat=%h", e.name, ack, err, dat_o, e.err, e.dat);
          end
        end
      end
    end
  end

  task automatic bus(input string name, input logic w, input logic [AW-1:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     input logic xerr, input logic [31:0] xdat);
    exp_q.push_back('{err: xerr, dat: xdat, chk: (!w || xerr), name: name});
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    @(posedge clk); #1;
    check({name, "_resp"}, {30'd0, ack, err}, {30'd0, !xerr, xerr});
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check({name, "_pulse"}, {30'd0, ack, err}, 32'd0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; dat_i = '0; sel = '0; gpio_in = '0;
    wait_cycles(3);
    check("reset_ack", {31'd0, ack}, 32'd0);
    check("reset_dat", dat_o, 32'd0);
    check("reset_inta", {31'd0, inta}, 32'd0);
    @(negedge clk); rst = 1'b0;
    check("reset_en", 32'(gpio_en), 32'd0);
    check("reset_out", 32'(gpio_out), 32'd0);

    for (int i = 0; i < 8; i++) begin
      bus($sformatf("rd_reset_%0d", i), 1'b0, AW'(i * 4), 32'd0, 4'hF, 1'b0, 32'd0);
    end

    // Byte lanes and atomic set/clear
    bus("wr_oe", 1'b1, 8'h08, 32'h0000_FF00, 4'b1111, 1'b0, 32'd0);
    check("en_gpio", 32'(gpio_en), 32'h0000_FF00);
    bus("wr_out_lane0", 1'b1, 8'h04, 32'h0012_3456, 4'b0001, 1'b0, 32'd0);
    bus("rd_out_lane0", 1'b0, 8'h04, 32'd0, 4'hF, 1'b0, 32'h0000_0056);
    check("o_gpio_lane0", 32'(gpio_out), 32'h0000_0056);
    bus("wr_out_set", 1'b1, 8'h18, 32'h0000_0100, 4'hF, 1'b0, 32'd0);
    bus("rd_out_set", 1'b0, 8'h04, 32'd0, 4'hF, 1'b0, 32'h0000_0156);
    bus("wr_out_clr", 1'b1, 8'h1C, 32'h0000_0006, 4'hF, 1'b0, 32'd0);
    bus("rd_out_clr", 1'b0, 8'h04, 32'd0, 4'hF, 1'b0, 32'h0000_0150);
    check("o_gpio_clr", 32'(gpio_out), 32'h0000_0150);
    bus("rd_set_reg", 1'b0, 8'h18, 32'd0, 4'hF, 1'b0, 32'd0);
    bus("rd_clr_reg", 1'b0, 8'h1C, 32'd0, 4'hF, 1'b0, 32'd0);
    bus("rd_oe", 1'b0, 8'h08, 32'd0, 4'hF, 1'b0, 32'h0000_FF00);

    // Rising edge on pin 0 with latency SS+1
    bus("wr_ptrig1", 1'b1, 8'h10, 32'h1, 4'hF, 1'b0, 32'd0);
    bus("wr_inte1", 1'b1, 8'h0C, 32'h1, 4'hF, 1'b0, 32'd0);
    @(negedge clk); gpio_in[0] = 1'b1;
    @(posedge clk);
    wait_cycles(1);
    check("inta_early", {31'd0, inta}, 32'd0);
    wait_cycles(1);
    check("inta_rise", {31'd0, inta}, 32'd1);
    bus("rd_ints_rise", 1'b0, 8'h14, 32'd0, 4'hF, 1'b0, 32'h1);
    bus("rd_in", 1'b0, 8'h00, 32'd0, 4'hF, 1'b0, 32'h1);
    bus("w1c_ints", 1'b1, 8'h14, 32'h1, 4'hF, 1'b0, 32'd0);
    check("inta_cleared", {31'd0, inta}, 32'd0);
    @(negedge clk); gpio_in[0] = 1'b0;
    wait_cycles(5);
    bus("rd_ints_fall_ignored", 1'b0, 8'h14, 32'd0, 4'hF, 1'b0, 32'd0);
    check("inta_fall_ignored", {31'd0, inta}, 32'd0);

    // Falling edge on pin 5 with interrupt masked, then unmasked
    bus("wr_ptrig0", 1'b1, 8'h10, 32'h0, 4'hF, 1'b0, 32'd0);
    bus("wr_inte0", 1'b1, 8'h0C, 32'h0, 4'hF, 1'b0, 32'd0);
    @(negedge clk); gpio_in[5] = 1'b1;
    wait_cycles(5);
    @(negedge clk); gpio_in[5] = 1'b0;
    wait_cycles(5);
    bus("rd_ints_pin5", 1'b0, 8'h14, 32'd0, 4'hF, 1'b0, 32'h20);
    check("inta_masked", {31'd0, inta}, 32'd0);
    bus("wr_inte20", 1'b1, 8'h0C, 32'h20, 4'hF, 1'b0, 32'd0);
    check("inta_unmasked", {31'd0, inta}, 32'd1);

    // Set beats a simultaneous W1C on bit 2
    @(negedge clk); gpio_in[2] = 1'b1;
    wait_cycles(5);
    @(negedge clk); gpio_in[2] = 1'b0;
    wait_cycles(5);
    bus("rd_ints_pin2", 1'b0, 8'h14, 32'd0, 4'hF, 1'b0, 32'h24);
    @(negedge clk); gpio_in[2] = 1'b1;
    wait_cycles(5);
    @(negedge clk); gpio_in[2] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    bus("w1c_collide", 1'b1, 8'h14, 32'h4, 4'hF, 1'b0, 32'd0);
    bus("rd_ints_collide", 1'b0, 8'h14, 32'd0, 4'hF, 1'b0, 32'h24);

    // Out-of-range addresses terminate with err and change nothing
    bus("err_wr_40", 1'b1, 8'h40, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'd0);
    bus("err_wr_44", 1'b1, 8'h44, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'd0);
    bus("err_rd_48", 1'b0, 8'h48, 32'd0, 4'hF, 1'b1, 32'd0);
    bus("rd_out_after_err", 1'b0, 8'h04, 32'd0, 4'hF, 1'b0, 32'h0000_0150);
    check("o_gpio_after_err", 32'(gpio_out), 32'h0000_0150);

    // Reset asserted while an ack is on the bus
    exp_q.push_back('{err: 1'b0, dat: 32'h0000_FF00, chk: 1'b1, name: "rd_oe_reset"});
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h08; sel = 4'hF;
    @(posedge clk); #1;
    check("reset_mid_ack", {31'd0, ack}, 32'd1);
    cyc = 1'b0; stb = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    check("reset_mid_ack_drop", {30'd0, ack, err}, 32'd0);
    check("reset_mid_inta", {31'd0, inta}, 32'd0);
    rst = 1'b0;
    check("reset_mid_en", 32'(gpio_en), 32'd0);
    check("reset_mid_out", 32'(gpio_out), 32'd0);
    for (int i = 1; i < 6; i++) begin
      bus($sformatf("rd_after_reset_%0d", i), 1'b0, AW'(i * 4), 32'd0, 4'hF, 1'b0, 32'd0);
    end

    wait_cycles(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
